alu_issue_driver: RTL and testbench
===================================

# alu_issue_driver

Sequential front end that drives the MIPS ALU. It accepts abstract operation requests over a valid/ready handshake and encodes each into a 32-bit MIPS instruction word plus operands. It holds them stable on the ALU inputs for a settle window, then captures result and flags into a response returned over a second valid/ready handshake. It sits between the pipeline's decode/issue logic (or a bench sequencer) and the combinational `alu`.

## Interface
- `SETTLE`, default 1: cycles instruction/operands are held before capture (1..15)
- `NOPS`, default 27: number of legal `op_sel` codes
- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `req_valid` in 1: request present
- `req_ready` out 1: driver can accept a request
- `req_op` in 5: operation select (package enum `alu_op_e`)
- `req_a` in 32: rs operand
- `req_b` in 32: rt operand
- `req_shamt` in 5: shift amount for SLL/SRL/SRA
- `req_imm` in 16: immediate for I-type ops
- `alu_instr` out 32: instruction word to ALU
- `alu_rega` out 32: regA to ALU
- `alu_regb` out 32: regB to ALU
- `alu_result` in 32: ALU result
- `alu_flags` in 3: ALU flags, passed through unmodified
- `resp_valid` out 1: response present
- `resp_ready` in 1: consumer accepts response
- `resp_result` out 32: captured result
- `resp_flags` out 3: captured flags
- `resp_instr` out 32: instruction word that produced the response
- `resp_err` out 1: illegal op (only with `ALU_DRV_CHECK_EN`)

## Operation
- FSM states: IDLE, HOLD, RESP.
- IDLE: `req_ready`=1. On `req_valid`, register the encoded instruction, `req_a`, `req_b`, load settle counter = SETTLE-1, go to HOLD.
- HOLD: `alu_*` outputs stable. Counter decrements. At 0, capture `alu_result`, `alu_flags` and `alu_instr` into resp registers and go to RESP.
- RESP: `resp_valid`=1, outputs stable. On `resp_ready` go to IDLE. There is no bypass: a new request is not accepted in the same cycle as the handshake.
- Encoding uses fixed register fields rs=0, rt=1, rd=2.
  - R-type: opcode 0; funct add 20h, addu 21h, sub 22h, subu 23h, and 24h, or 25h, xor 26h, nor 27h, slt 2Ah, sltu 2Bh, sll 00h, srl 02h, sra 03h, sllv 04h, srlv 06h, srav 07h.
  - shamt = `req_shamt` for sll/srl/sra, otherwise 0.
  - I-type opcodes: addi 08h, addiu 09h, slti 0Ah, sltiu 0Bh, andi 0Ch, ori 0Dh, xori 0Eh, beq 04h, bne 05h, lw 23h, sw 2Bh. Bits [15:0] = `req_imm`.
- Reset from any state: go to IDLE and drop any pending transaction.
- Reset values: `req_ready`=0 in the reset cycle and 1 after it; all other outputs are 0.

## Timing
- Accept at edge N. `alu_*` valid from N+1. Capture at edge N+SETTLE. `resp_valid` high from N+SETTLE.
- Minimum request-to-request spacing is SETTLE+2 cycles when `resp_ready` is held at 1.
- `resp_*` stay stable while `resp_valid`=1 and `resp_ready`=0.
- `alu_*` hold their last value in IDLE and RESP. They change only on acceptance.

## Configuration
- `ALU_DRV_CHECK_EN` defined:
  - `req_op` >= NOPS is accepted but not issued. `alu_*` are unchanged.
  - The FSM goes directly to RESP with `resp_err`=1, `resp_result`=0, `resp_flags`=0, `resp_instr`=0.
- `ALU_DRV_CHECK_EN` undefined:
  - An illegal op encodes as 32'h0000_0000 (sll $0 nop) and is issued normally.
  - `resp_err` is tied to 0.

## Structure
- Package `alu_drv_pkg` holds:
  - enum `alu_op_e` (ADD=0 … SW=26, listed in the order above);
  - opcode/funct localparams;
  - fixed register-field constants;
  - function `encode_instr(op, shamt, imm)`.
- One sub-module, `alu_instr_encoder`, is natural: combinational and wrapping `encode_instr`. The FSM, counter and response registers stay in the top module.

## Test plan
- ADD, a=8000_0009h, b=8000_0005h, SETTLE=1: `alu_instr`=0001_1020h from N+1. `resp_valid` at N+1. `resp_result`/`resp_flags` equal the ALU values sampled at N+1.
- SLL with shamt=3 gives `alu_instr`=0001_10C0h. ADDI with imm=FFFFh gives 2001_FFFFh. BNE with imm=80FEh gives 1401_80FEh.
- SETTLE=4, `resp_ready` held 0 for 10 cycles: response held stable, `req_ready`=0 throughout, next request accepted the cycle after `resp_ready`=1.
- Assert `reset` during HOLD: next cycle in IDLE, `resp_valid`=0, all outputs 0. A fresh request then completes normally.
- `req_op`=30 with `ALU_DRV_CHECK_EN`: `resp_err`=1 one cycle after acceptance, `alu_instr` unchanged. Without the macro: `alu_instr`=0, `resp_err`=0.
- Back-to-back SLTU requests with `resp_ready`=1: accepts spaced exactly SETTLE+2 cycles, responses in order.

Source files
------------

// File: rtl/alu_drv_pkg.sv
// Shared definitions for the ALU issue driver: operation enum, MIPS field constants, encoder.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package alu_drv_pkg;

  // Abstract operation select, in the order the issue logic numbers them.
  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,  OP_ADDU  = 5'd1,  OP_SUB   = 5'd2,  OP_SUBU  = 5'd3,
    OP_AND   = 5'd4,  OP_OR    = 5'd5,  OP_XOR   = 5'd6,  OP_NOR   = 5'd7,
    OP_SLT   = 5'd8,  OP_SLTU  = 5'd9,  OP_SLL   = 5'd10, OP_SRL   = 5'd11,
    OP_SRA   = 5'd12, OP_SLLV  = 5'd13, OP_SRLV  = 5'd14, OP_SRAV  = 5'd15,
    OP_ADDI  = 5'd16, OP_ADDIU = 5'd17, OP_SLTI  = 5'd18, OP_SLTIU = 5'd19,
    OP_ANDI  = 5'd20, OP_ORI   = 5'd21, OP_XORI  = 5'd22, OP_BEQ   = 5'd23,
    OP_BNE   = 5'd24, OP_LW    = 5'd25, OP_SW    = 5'd26
  } alu_op_e;

  // R-type opcode and function codes
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] FN_ADD  = 6'h20, FN_ADDU = 6'h21, FN_SUB  = 6'h22, FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24, FN_OR   = 6'h25, FN_XOR  = 6'h26, FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A, FN_SLTU = 6'h2B;
  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04, FN_SRLV = 6'h06, FN_SRAV = 6'h07;

  // I-type opcodes
  localparam logic [5:0] OPC_ADDI = 6'h08, OPC_ADDIU = 6'h09, OPC_SLTI = 6'h0A, OPC_SLTIU = 6'h0B;
  localparam logic [5:0] OPC_ANDI = 6'h0C, OPC_ORI   = 6'h0D, OPC_XORI = 6'h0E;
  localparam logic [5:0] OPC_BEQ  = 6'h04, OPC_BNE   = 6'h05, OPC_LW   = 6'h23, OPC_SW    = 6'h2B;

  // Register fields are fixed: operands always arrive via regA/regB, not a register file.
  localparam logic [4:0] RS_FIELD = 5'd0;
  localparam logic [4:0] RT_FIELD = 5'd1;
  localparam logic [4:0] RD_FIELD = 5'd2;

  // Build the instruction word. Unknown op codes yield 0 (sll $0,$0,0 == nop).
  function automatic logic [31:0] encode_instr(input logic [4:0] op,
                                               input logic [4:0] shamt,
                                               input logic [15:0] imm);
    logic [5:0]  fn;
    logic [5:0]  opc;
    logic        rtype;
    logic        legal;
    logic [4:0]  sh;
    logic [31:0] word;
    fn    = 6'h00;
    opc   = 6'h00;
    rtype = 1'b1;
    legal = 1'b1;
    sh    = 5'd0;
    case (alu_op_e'(op))
      OP_ADD:   fn = FN_ADD;
      OP_ADDU:  fn = FN_ADDU;
      OP_SUB:   fn = FN_SUB;
      OP_SUBU:  fn = FN_SUBU;
      OP_AND:   fn = FN_AND;
      OP_OR:    fn = FN_OR;
      OP_XOR:   fn = FN_XOR;
      OP_NOR:   fn = FN_NOR;
      OP_SLT:   fn = FN_SLT;
      OP_SLTU:  fn = FN_SLTU;
      OP_SLL:   begin fn = FN_SLL; sh = shamt; end
      OP_SRL:   begin fn = FN_SRL; sh = shamt; end
      OP_SRA:   begin fn = FN_SRA; sh = shamt; end
      OP_SLLV:  fn = FN_SLLV;
      OP_SRLV:  fn = FN_SRLV;
      OP_SRAV:  fn = FN_SRAV;
      OP_ADDI:  begin rtype = 1'b0; opc = OPC_ADDI;  end
      OP_ADDIU: begin rtype = 1'b0; opc = OPC_ADDIU; end
      OP_SLTI:  begin rtype = 1'b0; opc = OPC_SLTI;  end
      OP_SLTIU: begin rtype = 1'b0; opc = OPC_SLTIU; end
      OP_ANDI:  begin rtype = 1'b0; opc = OPC_ANDI;  end
      OP_ORI:   begin rtype = 1'b0; opc = OPC_ORI;   end
      OP_XORI:  begin rtype = 1'b0; opc = OPC_XORI;  end
      OP_BEQ:   begin rtype = 1'b0; opc = OPC_BEQ;   end
      OP_BNE:   begin rtype = 1'b0; opc = OPC_BNE;   end
      OP_LW:    begin rtype = 1'b0; opc = OPC_LW;    end
      OP_SW:    begin rtype = 1'b0; opc = OPC_SW;    end
      default:  legal = 1'b0;
    endcase
    if (!legal)
      word = 32'h0000_0000;
    else if (rtype)
      word = {OPC_RTYPE, RS_FIELD, RT_FIELD, RD_FIELD, sh, fn};
    else
      word = {opc, RS_FIELD, RT_FIELD, imm};
    return word;
  endfunction

endpackage

// File: rtl/alu_issue_driver_encoder.sv
// Combinational MIPS instruction encoder wrapping alu_drv_pkg::encode_instr.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
// Ports: op/shamt/imm in, instr out (32-bit instruction word).
module alu_instr_encoder
  import alu_drv_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  output logic [31:0] instr
);

  assign instr = encode_instr(op, shamt, imm);

endmodule

// File: rtl/alu_issue_driver.sv
// Encodes op requests into MIPS words, holds them on the ALU, captures result+flags as a response.
// Latency: accept at edge N, capture/resp_valid at edge N+SETTLE; back-to-back spacing SETTLE+2.
// Backpressure: req_ready low from accept until the response handshakes; resp_* held while resp_ready=0.
// Ports: clk/reset (sync, active-high); req_valid/req_ready/req_op/req_a/req_b/req_shamt/req_imm;
//        alu_instr/alu_rega/alu_regb to ALU, alu_result/alu_flags from ALU;
//        resp_valid/resp_ready/resp_result/resp_flags/resp_instr/resp_err.
// Option: define ALU_DRV_CHECK_EN to return illegal ops (req_op >= NOPS) as resp_err without issuing.
module alu_issue_driver #(
  parameter int unsigned SETTLE = 1,
  parameter int unsigned NOPS   = 27
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [4:0]  req_shamt,
  input  logic [15:0] req_imm,
  output logic [31:0] alu_instr,
  output logic [31:0] alu_rega,
  output logic [31:0] alu_regb,
  input  logic [31:0] alu_result,
  input  logic [2:0]  alu_flags,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_result,
  output logic [2:0]  resp_flags,
  output logic [31:0] resp_instr,
  output logic        resp_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HOLD = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        ready_q;
  logic [31:0] enc_instr;
  logic [31:0] issue_instr;
  logic        op_illegal;
  logic        accept;

  alu_instr_encoder u_enc (
    .op    (req_op),
    .shamt (req_shamt),
    .imm   (req_imm),
    .instr (enc_instr)
  );

  // NOPS may be configured below the enum size; anything at or above it is a nop.
  assign op_illegal  = ({27'd0, req_op} >= NOPS);
  assign issue_instr = op_illegal ? 32'h0000_0000 : enc_instr;

  // ready is registered so it reads 0 in the cycle right after a reset edge.
  assign req_ready  = ready_q;
  assign accept     = req_valid & ready_q;
  assign resp_valid = (state == RESP);

`ifdef ALU_DRV_CHECK_EN
  logic err_q;
  assign resp_err = err_q;
`else
  assign resp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      ready_q     <= 1'b0;
      alu_instr   <= 32'h0;
      alu_rega    <= 32'h0;
      alu_regb    <= 32'h0;
      resp_result <= 32'h0;
      resp_flags  <= 3'h0;
      resp_instr  <= 32'h0;
`ifdef ALU_DRV_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            ready_q <= 1'b0;
`ifdef ALU_DRV_CHECK_EN
            if (op_illegal) begin
              // Rejected op: ALU inputs untouched, answer straight away.
              state       <= RESP;
              resp_result <= 32'h0;
              resp_flags  <= 3'h0;
              resp_instr  <= 32'h0;
              err_q       <= 1'b1;
            end else
`endif
            begin
              alu_instr <= issue_instr;
              alu_rega  <= req_a;
              alu_regb  <= req_b;
              cnt       <= 4'(SETTLE - 1);
              state     <= HOLD;
            end
          end else begin
            ready_q <= 1'b1;
          end
        end
        HOLD: begin
          if (cnt == 4'd0) begin
            resp_result <= alu_result;
            resp_flags  <= alu_flags;
            resp_instr  <= alu_instr;
`ifdef ALU_DRV_CHECK_EN
            err_q       <= 1'b0;
`endif
            state       <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          // No bypass: the next request is only taken from IDLE.
          if (resp_ready) begin
            state   <= IDLE;
            ready_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_driver.sv
module tb_alu_issue_driver;

  localparam int unsigned SETTLE = 4;
  localparam int unsigned NOPS   = 27;
`ifdef ALU_DRV_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  // Spec tables: R-type funct by op 0..15, I-type opcode by op 16..26
  localparam int FUNCT [16] = '{32, 33, 34, 35, 36, 37, 38, 39, 42, 43, 0, 2, 3, 4, 6, 7};
  localparam int OPC   [11] = '{8, 9, 10, 11, 12, 13, 14, 4, 5, 35, 43};

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op;
  logic [31:0] req_a, req_b;
  logic [4:0]  req_shamt;
  logic [15:0] req_imm;
  logic [31:0] alu_instr, alu_rega, alu_regb;
  logic [31:0] alu_result = 32'h0;
  logic [2:0]  alu_flags = 3'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_result;
  logic [2:0]  resp_flags;
  logic [31:0] resp_instr;
  logic        resp_err;

  always #5 clk = ~clk;

  alu_issue_driver #(.SETTLE(SETTLE), .NOPS(NOPS)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_shamt(req_shamt), .req_imm(req_imm),
    .alu_instr(alu_instr), .alu_rega(alu_rega), .alu_regb(alu_regb),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_flags(resp_flags),
    .resp_instr(resp_instr), .resp_err(resp_err)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in ALU: result depends on the cycle so capture timing is visible.
  function automatic logic [31:0] fake_res(logic [31:0] i, logic [31:0] a, logic [31:0] b, logic [31:0] c);
    return (a + b) ^ i ^ (c * 32'h0001_0003);
  endfunction
  function automatic logic [2:0] fake_fl(logic [31:0] i, logic [31:0] a, logic [31:0] c);
    return a[2:0] ^ i[5:3] ^ c[2:0];
  endfunction

  always @(negedge clk) begin
    alu_result = fake_res(alu_instr, alu_rega, alu_regb, cyc);
    alu_flags  = fake_fl(alu_instr, alu_rega, cyc);
  end

  function automatic logic [31:0] exp_instr(int op, logic [4:0] sh, logic [15:0] imm);
    logic [31:0] r;
    if (op < 16) begin
      r = 32'h0001_0000 + 32'h0000_1000 + 32'(FUNCT[op]);
      if (op >= 10 && op <= 12) r = r + (32'(sh) << 6);
    end else if (op < int'(NOPS)) begin
      r = (32'(OPC[op - 16]) << 26) + 32'h0001_0000 + 32'(imm);
    end else begin
      r = 32'h0;
    end
    return r;
  endfunction

  typedef struct {
    logic [31:0] res;
    logic [2:0]  fl;
    logic [31:0] ins;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] mdl_instr = 32'h0, mdl_a = 32'h0, mdl_b = 32'h0;
  bit          rr_rand = 1'b0;
  bit          rr_force = 1'b1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // resp_ready source: random or forced, updated away from the edge
  always @(posedge clk) begin
    #2;
    resp_ready = rr_rand ? 1'($urandom_range(0, 1)) : rr_force;
  end

  // Monitor: compare at every response handshake
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0 && resp_valid === 1'b1 && resp_ready === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL resp_unexpected: got result %0h with nothing outstanding", resp_result);
      end else begin
        e = sb.pop_front();
        check("resp", {resp_result, resp_flags, resp_instr, resp_err}, {e.res, e.fl, e.ins, e.err});
      end
    end
  end

  task automatic send(input int op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] sh, input logic [15:0] imm, output int unsigned acc);
    int   w;
    exp_t e;
    logic [31:0] ei;
    w = 0;
    req_valid = 1'b1; req_op = op[4:0]; req_a = a; req_b = b; req_shamt = sh; req_imm = imm;
    while (req_ready !== 1'b1 && w < 300) begin
      @(posedge clk); #1; w++;
    end
    if (req_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL accept_timeout: req_ready %b after %0d cycles, want 1", req_ready, w);
      req_valid = 1'b0;
      acc = 0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    acc = cyc;
    ei = exp_instr(op, sh, imm);
    if (CHK && op >= int'(NOPS)) begin
      e.res = 32'h0; e.fl = 3'h0; e.ins = 32'h0; e.err = 1'b1;
    end else begin
      mdl_instr = ei; mdl_a = a; mdl_b = b;
      e.res = fake_res(ei, a, b, acc + SETTLE - 1);
      e.fl  = fake_fl(ei, a, acc + SETTLE - 1);
      e.ins = ei;
      e.err = 1'b0;
    end
    sb.push_back(e);
    check("alu_inputs", {alu_instr, alu_rega, alu_regb}, {mdl_instr, mdl_a, mdl_b});
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 500) begin
      @(posedge clk); #1; w++;
    end
    check("drain", 128'(sb.size()), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned acc, hcyc;
    int unsigned accs[4];
    logic [31:0] snap_res, snap_ins;
    logic [2:0]  snap_fl;
    bit          ok;
    int          w;

    reset = 1'b1; req_valid = 1'b0; req_op = 5'd0; req_a = 32'h0; req_b = 32'h0;
    req_shamt = 5'd0; req_imm = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {req_ready, alu_instr, alu_rega, alu_regb, resp_valid,
                            resp_result, resp_flags, resp_instr, resp_err}, 128'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("ready_after_reset", 128'(req_ready), 128'd1);

    // Directed encodings
    send(0, 32'h8000_0009, 32'h8000_0005, 5'd0, 16'h0, acc);
    check("add_instr", alu_instr, 32'h0001_1020);
    send(10, $urandom, $urandom, 5'd3, 16'h0, acc);
    check("sll_instr", alu_instr, 32'h0001_10C0);
    send(16, $urandom, $urandom, 5'd0, 16'hFFFF, acc);
    check("addi_instr", alu_instr, 32'h2001_FFFF);
    send(24, $urandom, $urandom, 5'd0, 16'h80FE, acc);
    check("bne_instr", alu_instr, 32'h1401_80FE);
    drain();

    // Response stall with resp_ready low
    rr_force = 1'b0;
    @(posedge clk); #3;
    send(2, 32'h1234_5678, 32'h0F0F_0F0F, 5'd0, 16'h0, acc);
    w = 0;
    while (resp_valid !== 1'b1 && w < 50) begin @(posedge clk); #1; w++; end
    snap_res = resp_result; snap_fl = resp_flags; snap_ins = resp_instr;
    ok = (resp_valid === 1'b1);
    repeat (10) begin
      @(posedge clk); #1;
      if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_result !== snap_res ||
          resp_flags !== snap_fl || resp_instr !== snap_ins) ok = 1'b0;
    end
    check("stall_hold", 128'(ok), 128'd1);
    rr_force = 1'b1;
    w = 0;
    do begin @(posedge clk); #3; w++; end while (resp_valid !== 1'b0 && w < 50);
    hcyc = cyc;
    check("ready_after_hs", 128'(req_ready), 128'd1);
    send(3, $urandom, $urandom, 5'd0, 16'h0, acc);
    check("accept_after_hs", 128'(acc), 128'(hcyc + 1));
    drain();

    // Reset while in HOLD
    send(1, $urandom, $urandom, 5'd0, 16'h0, acc);
    reset = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    check("reset_in_hold", {req_ready, alu_instr, alu_rega, alu_regb, resp_valid,
                            resp_result, resp_flags, resp_instr, resp_err}, 128'd0);
    reset = 1'b0;
    mdl_instr = 32'h0; mdl_a = 32'h0; mdl_b = 32'h0;
    @(posedge clk); #1;
    check("ready_after_hold_reset", 128'(req_ready), 128'd1);
    send(5, $urandom, $urandom, 5'd0, 16'h0, acc);
    drain();

    // Illegal op
    send(30, $urandom, $urandom, 5'd0, 16'h0, acc);
    if (CHK) check("illegal_err", {resp_valid, resp_err}, 128'b11);
    else     check("illegal_instr", {alu_instr, resp_err}, 128'd0);
    drain();

    // Back-to-back SLTU with resp_ready held high
    for (int i = 0; i < 4; i++) send(9, $urandom, $urandom, 5'd0, 16'h0, accs[i]);
    for (int i = 1; i < 4; i++) check("b2b_spacing", 128'(accs[i] - accs[i-1]), 128'(SETTLE + 2));
    drain();

    // Random traffic with random resp_ready
    rr_rand = 1'b1;
    for (int i = 0; i < 120; i++) begin
      send(int'($urandom_range(0, 31)), $urandom, $urandom, 5'($urandom), 16'($urandom), acc);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
      #0;
    end
    rr_rand = 1'b0;
    rr_force = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
